decodificador_7seg: RTL and testbench

Registered 4-bit binary/hex to 7-segment display decoder. It drives one seven-segment digit, common-anode style by default, so segment outputs are active-low. It sits between switch or counter logic and the board display pins. The input code is captured on the clock, and the segment pattern is decoded from the captured value.

---
 rtl/decodificador_7seg.sv | 63 ++++++
 tb/tb_decodificador_7seg.sv | 136 +++++++++++++
 2 files changed

// File: rtl/decodificador_7seg.sv
// rtl/decodificador_7seg.sv - registered 4-bit hex to seven-segment decoder
module decodificador_7seg #(
  parameter bit ACTIVE_LOW = 1'b1,
  parameter bit HEX_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] SW,
  input  logic       blank,
  output logic [6:0] QQ
);

  logic [3:0] code_q, code_d;
  logic       blank_q, blank_d;
  logic [6:0] seg_ah;
  logic [6:0] seg_on;

  always_comb begin
    code_d  = SW;
    blank_d = blank;
  end

  // Reset leaves the digit blanked so the display is dark until real data arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      code_q  <= 4'd0;
      blank_q <= 1'b1;
    end else begin
      code_q  <= code_d;
      blank_q <= blank_d;
    end
  end

  // Pattern bit order is a b c d e f g, with 1 meaning the segment is lit.
  always_comb begin
    seg_ah = 7'b0000000;
    unique case (code_q)
      4'd0:  seg_ah = 7'b1111110;
      4'd1:  seg_ah = 7'b0110000;
      4'd2:  seg_ah = 7'b1101101;
      4'd3:  seg_ah = 7'b1111001;
      4'd4:  seg_ah = 7'b0110011;
      4'd5:  seg_ah = 7'b1011011;
      4'd6:  seg_ah = 7'b1011111;
      4'd7:  seg_ah = 7'b1110000;
      4'd8:  seg_ah = 7'b1111111;
      4'd9:  seg_ah = 7'b1111011;
      4'd10: seg_ah = HEX_EN ? 7'b1110111 : 7'b0000000;
      4'd11: seg_ah = HEX_EN ? 7'b0011111 : 7'b0000000;
      4'd12: seg_ah = HEX_EN ? 7'b1001110 : 7'b0000000;
      4'd13: seg_ah = HEX_EN ? 7'b0111101 : 7'b0000000;
      4'd14: seg_ah = HEX_EN ? 7'b1001111 : 7'b0000000;
      4'd15: seg_ah = HEX_EN ? 7'b1000111 : 7'b0000000;
      default: seg_ah = 7'b0000000;
    endcase
  end

  always_comb begin
    seg_on = blank_q ? 7'b0000000 : seg_ah;
    QQ     = ACTIVE_LOW ? ~seg_on : seg_on;
  end

endmodule

// File: tb/tb_decodificador_7seg.sv
// tb/tb_decodificador_7seg.sv - scoreboard bench for decodificador_7seg across parameter sets
module tb_decodificador_7seg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       blank = 1'b0;
  logic [3:0] SW = 4'd8;
  logic [6:0] qq_def, qq_nohex, qq_ah;

  always #5 clk = ~clk;

  decodificador_7seg #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b1)) u_def (
    .clk(clk), .rst(rst), .SW(SW), .blank(blank), .QQ(qq_def));
  decodificador_7seg #(.ACTIVE_LOW(1'b1), .HEX_EN(1'b0)) u_nohex (
    .clk(clk), .rst(rst), .SW(SW), .blank(blank), .QQ(qq_nohex));
  decodificador_7seg #(.ACTIVE_LOW(1'b0), .HEX_EN(1'b1)) u_ah (
    .clk(clk), .rst(rst), .SW(SW), .blank(blank), .QQ(qq_ah));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0] code;
    logic [6:0] e_def;
    logic [6:0] e_nohex;
    logic [6:0] e_ah;
  } exp_t;
  exp_t sb[$];

  function automatic logic [6:0] pattern(input logic [3:0] c, input bit hex_en);
    logic [6:0] p;
    case (c)
      4'd0:  p = 7'b1111110;
      4'd1:  p = 7'b0110000;
      4'd2:  p = 7'b1101101;
      4'd3:  p = 7'b1111001;
      4'd4:  p = 7'b0110011;
      4'd5:  p = 7'b1011011;
      4'd6:  p = 7'b1011111;
      4'd7:  p = 7'b1110000;
      4'd8:  p = 7'b1111111;
      4'd9:  p = 7'b1111011;
      4'd10: p = 7'b1110111;
      4'd11: p = 7'b0011111;
      4'd12: p = 7'b1001110;
      4'd13: p = 7'b0111101;
      4'd14: p = 7'b1001111;
      default: p = 7'b1000111;
    endcase
    if (!hex_en && c > 4'd9) p = 7'b0000000;
    return p;
  endfunction

  function automatic logic [6:0] model(input logic r, input logic b, input logic [3:0] c,
                                       input bit hex_en, input bit act_low);
    logic [6:0] p;
    p = (r || b) ? 7'b0000000 : pattern(c, hex_en);
    return act_low ? ~p : p;
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic [3:0] s, input logic b);
    exp_t e;
    @(negedge clk);
    rst = r;
    SW = s;
    blank = b;
    e.code    = s;
    e.e_def   = model(r, b, s, 1'b1, 1'b1);
    e.e_nohex = model(r, b, s, 1'b0, 1'b1);
    e.e_ah    = model(r, b, s, 1'b1, 1'b0);
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk($sformatf("def_code%0d", e.code), qq_def, e.e_def);
      chk($sformatf("nohex_code%0d", e.code), qq_nohex, e.e_nohex);
      chk($sformatf("acthigh_code%0d", e.code), qq_ah, e.e_ah);
    end
  endtask

  initial begin
    // Held in reset with SW=8: display must stay dark.
    step(1'b1, 4'd8, 1'b0);
    step(1'b1, 4'd8, 1'b0);
    chk("reset_literal", qq_def, 7'b1111111);
    step(1'b0, 4'd8, 1'b0);
    chk("first_digit8_literal", qq_def, 7'b0000000);

    for (int i = 0; i < 16; i++) step(1'b0, 4'(i), 1'b0);
    chk("hex_f_literal", qq_def, 7'b0111000);
    chk("nohex_f_literal", qq_nohex, 7'b1111111);

    // Change SW between edges: output must not move until the next edge.
    step(1'b0, 4'd1, 1'b0);
    @(negedge clk);
    SW = 4'd7;
    #2;
    chk("latency_hold", qq_def, 7'b1001111);
    @(posedge clk);
    #1;
    chk("latency_update", qq_def, 7'b0001111);

    step(1'b0, 4'd5, 1'b1);
    chk("blank_on_literal", qq_def, 7'b1111111);
    step(1'b0, 4'd5, 1'b0);
    chk("blank_off_literal", qq_def, 7'b0100100);

    step(1'b0, 4'd2, 1'b0);
    chk("acthigh_2_literal", qq_ah, 7'b1101101);

    // Reset in the middle of a sweep.
    step(1'b0, 4'd6, 1'b0);
    step(1'b1, 4'd6, 1'b0);
    chk("midreset_acthigh_literal", qq_ah, 7'b0000000);
    step(1'b0, 4'd6, 1'b0);
    step(1'b0, 4'd9, 1'b0);
    chk("after_reset_9_literal", qq_def, 7'b0000100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
